// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - control bundle between the micro-sequencer and the datapath/decoder
interface micro_sequencer_if;
    logic [6:0] opcode;
    logic       bcond;
    logic       mem_ready;
    logic       halt_req;

    logic       to_IR_from_MEM_PC;
    logic       to_A_from_RF_RS1;
    logic       to_B_from_RF_RS2;
    logic       to_ALUOut_from_PCp4;
    logic       to_ALUOut_from_ApB;
    logic       to_RF_rd_from_ALUOut;
    logic       to_PC_from_PCp4;
    logic       to_ALUOut_from_Apimm;
    logic       to_MDR_from_MEM_ALUOut;
    logic       to_RF_rd_from_MDR;
    logic       to_MEM_ALUOut_from_B;
    logic       to_PC_from_ALUOut;
    logic       to_PC_from_PCpimm;
    logic       to_PC_from_Apimm;

    logic [3:0] state;
    logic       retire;
    logic       halted;

    modport master (
        input  opcode, bcond, mem_ready, halt_req,
        output to_IR_from_MEM_PC, to_A_from_RF_RS1, to_B_from_RF_RS2, to_ALUOut_from_PCp4,
               to_ALUOut_from_ApB, to_RF_rd_from_ALUOut, to_PC_from_PCp4, to_ALUOut_from_Apimm,
               to_MDR_from_MEM_ALUOut, to_RF_rd_from_MDR, to_MEM_ALUOut_from_B, to_PC_from_ALUOut,
               to_PC_from_PCpimm, to_PC_from_Apimm, state, retire, halted
    );

    modport slave (
        output opcode, bcond, mem_ready, halt_req,
        input  to_IR_from_MEM_PC, to_A_from_RF_RS1, to_B_from_RF_RS2, to_ALUOut_from_PCp4,
               to_ALUOut_from_ApB, to_RF_rd_from_ALUOut, to_PC_from_PCp4, to_ALUOut_from_Apimm,
               to_MDR_from_MEM_ALUOut, to_RF_rd_from_MDR, to_MEM_ALUOut_from_B, to_PC_from_ALUOut,
               to_PC_from_PCpimm, to_PC_from_Apimm, state, retire, halted
    );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - multi-cycle RV32 control sequencer emitting per-state micro-op strobes
module micro_sequencer (
    input  logic              clk,
    input  logic              reset_n,
    micro_sequencer_if.master bus
);
    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_EXR   = 4'd2;
    localparam logic [3:0] S_EXI   = 4'd3;
    localparam logic [3:0] S_WBA   = 4'd4;
    localparam logic [3:0] S_ADDR  = 4'd5;
    localparam logic [3:0] S_LD4   = 4'd6;
    localparam logic [3:0] S_LD5   = 4'd7;
    localparam logic [3:0] S_SD4   = 4'd8;
    localparam logic [3:0] S_B3    = 4'd9;
    localparam logic [3:0] S_B4    = 4'd10;
    localparam logic [3:0] S_JAL3  = 4'd11;
    localparam logic [3:0] S_JALR3 = 4'd12;
    localparam logic [3:0] S_PCINC = 4'd13;
    localparam logic [3:0] S_HALT  = 4'd14;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IF;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    if (bus.mem_ready) state_d = S_ID;
            S_ID: begin
                case (bus.opcode)
                    OP_R:         state_d = S_EXR;
                    OP_I:         state_d = S_EXI;
                    OP_LD, OP_ST: state_d = S_ADDR;
                    OP_BR:        state_d = S_B3;
                    OP_JAL:       state_d = S_JAL3;
                    OP_JALR:      state_d = S_JALR3;
                    OP_SYS:       state_d = bus.halt_req ? S_HALT : S_PCINC;
                    default:      state_d = S_PCINC;
                endcase
            end
            S_EXR, S_EXI: state_d = S_WBA;
            S_ADDR:  state_d = (bus.opcode == OP_LD) ? S_LD4 : S_SD4;
            S_LD4:   if (bus.mem_ready) state_d = S_LD5;
            S_SD4:   if (bus.mem_ready) state_d = S_IF;
            S_B3:    state_d = bus.bcond ? S_B4 : S_IF;
            S_HALT:  state_d = S_HALT;
            // single-cycle tails and the unused code 15 all return to fetch
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        bus.to_IR_from_MEM_PC      = 1'b0;
        bus.to_A_from_RF_RS1       = 1'b0;
        bus.to_B_from_RF_RS2       = 1'b0;
        bus.to_ALUOut_from_PCp4    = 1'b0;
        bus.to_ALUOut_from_ApB     = 1'b0;
        bus.to_RF_rd_from_ALUOut   = 1'b0;
        bus.to_PC_from_PCp4        = 1'b0;
        bus.to_ALUOut_from_Apimm   = 1'b0;
        bus.to_MDR_from_MEM_ALUOut = 1'b0;
        bus.to_RF_rd_from_MDR      = 1'b0;
        bus.to_MEM_ALUOut_from_B   = 1'b0;
        bus.to_PC_from_ALUOut      = 1'b0;
        bus.to_PC_from_PCpimm      = 1'b0;
        bus.to_PC_from_Apimm       = 1'b0;
        case (state_q)
            S_IF:  bus.to_IR_from_MEM_PC = 1'b1;
            S_ID: begin
                bus.to_A_from_RF_RS1    = 1'b1;
                bus.to_B_from_RF_RS2    = 1'b1;
                bus.to_ALUOut_from_PCp4 = 1'b1;
            end
            S_EXR:         bus.to_ALUOut_from_ApB   = 1'b1;
            S_EXI, S_ADDR: bus.to_ALUOut_from_Apimm = 1'b1;
            S_WBA: begin
                bus.to_RF_rd_from_ALUOut = 1'b1;
                bus.to_PC_from_PCp4      = 1'b1;
            end
            S_LD4: bus.to_MDR_from_MEM_ALUOut = 1'b1;
            S_LD5: begin
                bus.to_RF_rd_from_MDR = 1'b1;
                bus.to_PC_from_PCp4   = 1'b1;
            end
            S_SD4: begin
                // PC advances only on the completing cycle so a stalled store bumps it once
                bus.to_MEM_ALUOut_from_B = 1'b1;
                bus.to_PC_from_PCp4      = bus.mem_ready;
            end
            S_B3:  bus.to_PC_from_ALUOut = 1'b1;
            S_B4:  bus.to_PC_from_PCpimm = 1'b1;
            S_JAL3: begin
                bus.to_RF_rd_from_ALUOut = 1'b1;
                bus.to_PC_from_PCpimm    = 1'b1;
            end
            S_JALR3: begin
                bus.to_RF_rd_from_ALUOut = 1'b1;
                bus.to_PC_from_Apimm     = 1'b1;
            end
            S_PCINC: bus.to_PC_from_PCp4 = 1'b1;
            default: ;
        endcase
    end

    assign bus.state  = state_q;
    assign bus.halted = (state_q == S_HALT);
    assign bus.retire = bus.to_PC_from_PCp4 | bus.to_PC_from_PCpimm | bus.to_PC_from_Apimm |
                        ((state_q == S_B3) & ~bus.bcond);
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed bench with an instruction-level expected-trace model
module tb_micro_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    micro_sequencer_if bus ();
    micro_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    localparam logic [13:0] B_IR = 14'd1 << 0,  B_A = 14'd1 << 1,  B_B = 14'd1 << 2,  B_ALUPC4 = 14'd1 << 3;
    localparam logic [13:0] B_APB = 14'd1 << 4, B_RFALU = 14'd1 << 5, B_PC4 = 14'd1 << 6, B_APIMM = 14'd1 << 7;
    localparam logic [13:0] B_MDR = 14'd1 << 8, B_RFMDR = 14'd1 << 9, B_MEMB = 14'd1 << 10, B_PCALU = 14'd1 << 11;
    localparam logic [13:0] B_PCPIMM = 14'd1 << 12, B_PCAPIMM = 14'd1 << 13;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_SYS = 7, K_OTH = 8;

    typedef struct {
        logic        mr;
        logic [3:0]  st;
        logic [13:0] sb;
        logic        ret;
        logic        hlt;
    } rec_t;

    rec_t       q[$];
    logic [6:0] cur_op;
    logic       cur_bc, cur_hr;
    int         n_cmp = 0, n_bad = 0;

    wire [13:0] dut_sb = {bus.to_PC_from_Apimm, bus.to_PC_from_PCpimm, bus.to_PC_from_ALUOut,
                          bus.to_MEM_ALUOut_from_B, bus.to_RF_rd_from_MDR, bus.to_MDR_from_MEM_ALUOut,
                          bus.to_ALUOut_from_Apimm, bus.to_PC_from_PCp4, bus.to_RF_rd_from_ALUOut,
                          bus.to_ALUOut_from_ApB, bus.to_ALUOut_from_PCp4, bus.to_B_from_RF_RS2,
                          bus.to_A_from_RF_RS1, bus.to_IR_from_MEM_PC};

    function automatic logic rb();
        return logic'($urandom_range(1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic mr, input logic [3:0] st, input logic [13:0] sb,
                       input logic ret, input logic hlt);
        rec_t r;
        r.mr = mr; r.st = st; r.sb = sb; r.ret = ret; r.hlt = hlt;
        q.push_back(r);
    endtask

    // One instruction as the datapath sees it: fetch, decode, then the class-specific phases.
    // Memory phases burn one cycle per stall; exactly one record carries the PC update (retire).
    task automatic build(input int kind, input int if_stall, input int mem_stall,
                         input logic bc, input logic hr);
        cur_bc = bc; cur_hr = hr;
        case (kind)
            K_R:    cur_op = 7'b0110011;
            K_I:    cur_op = 7'b0010011;
            K_LD:   cur_op = 7'b0000011;
            K_ST:   cur_op = 7'b0100011;
            K_BR:   cur_op = 7'b1100011;
            K_JAL:  cur_op = 7'b1101111;
            K_JALR: cur_op = 7'b1100111;
            K_SYS:  cur_op = 7'b1110011;
            default: cur_op = 7'b0110111;
        endcase
        for (int i = 0; i < if_stall; i++) add(1'b0, 4'd0, B_IR, 1'b0, 1'b0);
        add(1'b1, 4'd0, B_IR, 1'b0, 1'b0);
        add(rb(), 4'd1, B_A | B_B | B_ALUPC4, 1'b0, 1'b0);
        case (kind)
            K_R: begin
                add(rb(), 4'd2, B_APB, 1'b0, 1'b0);
                add(rb(), 4'd4, B_RFALU | B_PC4, 1'b1, 1'b0);
            end
            K_I: begin
                add(rb(), 4'd3, B_APIMM, 1'b0, 1'b0);
                add(rb(), 4'd4, B_RFALU | B_PC4, 1'b1, 1'b0);
            end
            K_LD: begin
                add(rb(), 4'd5, B_APIMM, 1'b0, 1'b0);
                for (int i = 0; i < mem_stall; i++) add(1'b0, 4'd6, B_MDR, 1'b0, 1'b0);
                add(1'b1, 4'd6, B_MDR, 1'b0, 1'b0);
                add(rb(), 4'd7, B_RFMDR | B_PC4, 1'b1, 1'b0);
            end
            K_ST: begin
                add(rb(), 4'd5, B_APIMM, 1'b0, 1'b0);
                for (int i = 0; i < mem_stall; i++) add(1'b0, 4'd8, B_MEMB, 1'b0, 1'b0);
                add(1'b1, 4'd8, B_MEMB | B_PC4, 1'b1, 1'b0);
            end
            K_BR: begin
                add(rb(), 4'd9, B_PCALU, !bc, 1'b0);
                if (bc) add(rb(), 4'd10, B_PCPIMM, 1'b1, 1'b0);
            end
            K_JAL:  add(rb(), 4'd11, B_RFALU | B_PCPIMM, 1'b1, 1'b0);
            K_JALR: add(rb(), 4'd12, B_RFALU | B_PCAPIMM, 1'b1, 1'b0);
            K_SYS: begin
                if (hr) for (int i = 0; i < 21; i++) add(rb(), 4'd14, 14'd0, 1'b0, 1'b1);
                else    add(rb(), 4'd13, B_PC4, 1'b1, 1'b0);
            end
            default: add(rb(), 4'd13, B_PC4, 1'b1, 1'b0);
        endcase
    endtask

    function automatic logic [31:0] trace();
        logic [31:0] t = 0;
        foreach (q[i]) t = (t << 4) | 32'(q[i].st);
        return t;
    endfunction

    // Single compare process: drive each record's inputs away from the edge, then check outputs.
    task automatic play(input int limit);
        int k = 0;
        while (q.size() > 0 && k < limit) begin
            rec_t r = q.pop_front();
            @(negedge clk);
            bus.opcode = cur_op; bus.bcond = cur_bc; bus.halt_req = cur_hr; bus.mem_ready = r.mr;
            #1;
            chk($sformatf("state[%0d]", k), 32'(bus.state), 32'(r.st));
            chk($sformatf("strobes[%0d]", k), 32'(dut_sb), 32'(r.sb));
            chk($sformatf("retire[%0d]", k), 32'(bus.retire), 32'(r.ret));
            chk($sformatf("halted[%0d]", k), 32'(bus.halted), 32'(r.hlt));
            k++;
        end
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
        chk({tag, "_strobes"}, 32'(dut_sb), 32'(B_IR));
        chk({tag, "_retire"}, 32'(bus.retire), 32'd0);
        chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bus.opcode = 7'd0; bus.bcond = 1'b0; bus.halt_req = 1'b0; bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("reset");
        release_reset();

        build(K_R, 0, 0, 1'b0, 1'b0);
        chk("model_r_trace", trace(), 32'h0124);
        play(1000);
        build(K_I, 1, 0, 1'b0, 1'b0);   play(1000);
        build(K_LD, 0, 2, 1'b0, 1'b0);
        chk("model_ld_trace", trace(), 32'h0156667);
        play(1000);
        build(K_ST, 0, 2, 1'b0, 1'b0);
        cnt = 0;
        foreach (q[i]) if (q[i].sb & B_MEMB) cnt++;
        chk("model_st_memb_cycles", 32'(cnt), 32'd3);
        play(1000);
        build(K_BR, 0, 0, 1'b0, 1'b0);
        chk("model_br_nt_trace", trace(), 32'h019);
        play(1000);
        build(K_BR, 2, 0, 1'b1, 1'b0);
        chk("model_br_t_trace", trace(), 32'h00019A);
        play(1000);
        build(K_JAL, 0, 0, 1'b0, 1'b0);  play(1000);
        build(K_JALR, 0, 0, 1'b1, 1'b1); play(1000);
        build(K_OTH, 0, 0, 1'b0, 1'b1);  play(1000);
        build(K_SYS, 0, 0, 1'b0, 1'b0);
        chk("model_ecall_trace", trace(), 32'h01D);
        play(1000);

        build(K_LD, 0, 3, 1'b0, 1'b0);
        play(4);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_mid_ld4");
        release_reset();
        #1 chk("post_release_state", 32'(bus.state), 32'd0);

        build(K_ST, 1, 0, 1'b0, 1'b0);   play(1000);
        build(K_SYS, 0, 0, 1'b0, 1'b1);  play(1000);
        @(negedge clk);
        #1 chk("halt_held_state", 32'(bus.state), 32'd14);
        reset_n = 1'b0;
        #1 check_reset_outputs("reset_in_halt");
        release_reset();
        build(K_R, 0, 0, 1'b0, 1'b0);    play(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
